// File: rtl/multi_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences IF/ID/EX/MEM/WB and
// decodes every datapath enable and select from the current state and the IR fields.
module multi_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 dmem_ready,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 ir_we,
    output logic                 ext_type,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 reg_we,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 illegal,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 retire;
    logic [CNT_WIDTH-1:0] retired_q;

    logic is_rtype, is_addu, is_subu, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, legal, ext_sign;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addu  = is_rtype && (funct == FN_ADDU);
    assign is_subu  = is_rtype && (funct == FN_SUBU);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign legal    = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw |
                      is_beq | is_j | is_jal;
    assign ext_sign = is_lw | is_sw | is_beq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d    = S_IF;
        retire     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        ir_we      = 1'b0;
        ext_type   = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IF: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                ext_type = ext_sign;
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else if (is_j || is_jal) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    retire  = 1'b1;
                    state_d = S_IF;
                    if (is_jal) begin
                        reg_we     = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                ext_type = ext_sign;
                if (is_rtype) begin
                    alu_op  = is_subu ? ALU_SUB : ALU_ADD;
                    state_d = S_WB;
                end else if (is_ori) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_OR;
                    state_d = S_WB;
                end else if (is_lui) begin
                    alu_op  = ALU_LUI;
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else if (is_beq) begin
                    alu_op  = ALU_SUB;
                    pc_we   = zero;
                    pc_src  = 2'd1;
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                ext_type = ext_sign;
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (!dmem_ready) begin
                    state_d = S_MEM;
                end else if (is_lw) begin
                    state_d = S_WB;
                end else begin
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB: begin
                ext_type   = ext_sign;
                reg_we     = 1'b1;
                reg_dst    = {1'b0, is_rtype};
                mem_to_reg = {1'b0, is_lw};
                retire     = 1'b1;
                state_d    = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Reset holds state at IF, whose enables would otherwise be active.
        if (!rst_n) begin
            pc_we      = 1'b0;
            pc_src     = 2'd0;
            ir_we      = 1'b0;
            ext_type   = 1'b0;
            alu_src    = 1'b0;
            alu_op     = ALU_ADD;
            reg_we     = 1'b0;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multi_ctrl.sv
// Bench for multi_ctrl: directed and random instruction streams checked cycle by
// cycle against a per-instruction reference of state sequence and control outputs.
module tb_multi_ctrl;

    localparam int CW = 4;

    localparam int K_ADDU = 0;
    localparam int K_SUBU = 1;
    localparam int K_ORI  = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_J    = 7;
    localparam int K_JAL  = 8;
    localparam int K_ILL  = 9;

    localparam int ST_IF  = 0;
    localparam int ST_ID  = 1;
    localparam int ST_EX  = 2;
    localparam int ST_MEM = 3;
    localparam int ST_WB  = 4;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       ext_type;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       dmem_req;
        logic       dmem_we;
        logic       illegal;
        logic [2:0] state;
    } outs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode, funct;
    logic          zero, dmem_ready;
    logic          pc_we, ir_we, ext_type, alu_src, reg_we;
    logic          dmem_req, dmem_we, illegal;
    logic [1:0]    pc_src, alu_op, reg_dst, mem_to_reg;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    outs_t         obs;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;
    logic [5:0] ill_op, ill_fn;

    multi_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .dmem_ready(dmem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
        .ext_type(ext_type), .alu_src(alu_src), .alu_op(alu_op), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs = {pc_we, pc_src, ir_we, ext_type, alu_src, alu_op, reg_we,
                  reg_dst, mem_to_reg, dmem_req, dmem_we, illegal, state};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control outputs for one instruction kind in one pipeline phase.
    function automatic outs_t exp_outs(input int kind, input int st, input logic z);
        outs_t o;
        logic  sgn;
        o   = '0;
        sgn = (kind == K_LW) || (kind == K_SW) || (kind == K_BEQ);
        o.state = 3'(st);
        if (st != ST_IF) o.ext_type = sgn;
        case (st)
            ST_IF: begin o.ir_we = 1'b1; o.pc_we = 1'b1; end
            ST_ID: begin
                if (kind == K_ILL) o.illegal = 1'b1;
                if (kind == K_J || kind == K_JAL) begin o.pc_we = 1'b1; o.pc_src = 2'd2; end
                if (kind == K_JAL) begin o.reg_we = 1'b1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; end
            end
            ST_EX: begin
                case (kind)
                    K_SUBU:      o.alu_op = 2'd1;
                    K_ORI:       begin o.alu_src = 1'b1; o.alu_op = 2'd2; end
                    K_LUI:       o.alu_op = 2'd3;
                    K_LW, K_SW:  o.alu_src = 1'b1;
                    K_BEQ:       begin o.alu_op = 2'd1; o.pc_we = z; o.pc_src = 2'd1; end
                    default:     o.alu_op = 2'd0;
                endcase
            end
            ST_MEM: begin o.dmem_req = 1'b1; o.dmem_we = (kind == K_SW); end
            ST_WB: begin
                o.reg_we     = 1'b1;
                o.reg_dst    = (kind == K_ADDU || kind == K_SUBU) ? 2'd1 : 2'd0;
                o.mem_to_reg = (kind == K_LW) ? 2'd1 : 2'd0;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic set_enc(input int kind);
        funct = 6'($urandom_range(0, 63));
        case (kind)
            K_ADDU: begin opcode = 6'h00; funct = 6'h21; end
            K_SUBU: begin opcode = 6'h00; funct = 6'h23; end
            K_ORI:  opcode = 6'h0D;
            K_LUI:  opcode = 6'h0F;
            K_LW:   opcode = 6'h23;
            K_SW:   opcode = 6'h2B;
            K_BEQ:  opcode = 6'h04;
            K_J:    opcode = 6'h02;
            K_JAL:  opcode = 6'h03;
            default: begin opcode = ill_op; funct = ill_fn; end
        endcase
    endtask

    task automatic pick_illegal();
        case ($urandom_range(0, 3))
            0: begin ill_op = 6'h3F; ill_fn = 6'($urandom_range(0, 63)); end
            1: begin ill_op = 6'h00; ill_fn = 6'h20; end
            2: begin ill_op = 6'h08; ill_fn = 6'($urandom_range(0, 63)); end
            default: begin ill_op = 6'h00; ill_fn = 6'h00; end
        endcase
    endtask

    // Runs one instruction from its IF cycle; entered and left just after a falling edge.
    task automatic run_instr(input int kind, input logic z_ex, input int stalls);
        int sq[$];
        int mem_idx;
        sq = {ST_IF, ST_ID};
        case (kind)
            K_ADDU, K_SUBU, K_ORI, K_LUI: sq = {sq, ST_EX, ST_WB};
            K_BEQ: sq.push_back(ST_EX);
            K_SW, K_LW: begin
                sq.push_back(ST_EX);
                for (int s = 0; s <= stalls; s++) sq.push_back(ST_MEM);
                if (kind == K_LW) sq.push_back(ST_WB);
            end
            default: ;
        endcase
        set_enc(kind);
        mem_idx = 0;
        for (int i = 0; i < sq.size(); i++) begin
            zero = (sq[i] == ST_EX) ? z_ex : 1'($urandom_range(0, 1));
            if (sq[i] == ST_MEM) begin
                dmem_ready = (mem_idx == stalls);
                mem_idx++;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            check($sformatf("outs k%0d st%0d", kind, sq[i]), 32'(obs),
                  32'(exp_outs(kind, sq[i], zero)));
            check("retired", 32'(retired), 32'(exp_ret));
            @(posedge clk);
            @(negedge clk);
        end
        if (kind != K_ILL) exp_ret = (exp_ret + 1) % (1 << CW);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'h0; funct = 6'h0; zero = 1'b0; dmem_ready = 1'b0;
        ill_op = 6'h3F; ill_fn = 6'h00;
        #1;
        check("reset outs", 32'(obs), 32'h0);
        check("reset retired", 32'(retired), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hold outs", 32'(obs), 32'h0);
        rst_n = 1'b1;

        run_instr(K_ADDU, 1'b0, 0);
        run_instr(K_LW, 1'b0, 2);
        run_instr(K_BEQ, 1'b1, 0);
        run_instr(K_BEQ, 1'b0, 0);
        run_instr(K_ORI, 1'b1, 0);
        run_instr(K_JAL, 1'b0, 0);
        ill_op = 6'h3F; ill_fn = 6'h15;
        run_instr(K_ILL, 1'b0, 0);
        run_instr(K_SUBU, 1'b0, 0);
        run_instr(K_LUI, 1'b0, 0);
        run_instr(K_SW, 1'b0, 1);
        run_instr(K_J, 1'b0, 0);

        for (int n = 0; n < 200; n++) begin
            pick_illegal();
            run_instr(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
        end

        // Drive the counter to its top value, then retire one more to see it wrap.
        while (exp_ret != (1 << CW) - 1) run_instr(K_ADDU, 1'b0, 0);
        run_instr(K_J, 1'b0, 0);
        #1;
        check("wrap", 32'(retired), 32'h0);

        // Reset while a store is waiting in MEM.
        set_enc(K_SW);
        dmem_ready = 1'b0;
        run_instr(K_ADDU, 1'b0, 0);
        set_enc(K_SW);
        dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("sw mem state", 32'(state), 32'd3);
        check("sw mem req", 32'({dmem_req, dmem_we}), 32'h3);
        rst_n = 1'b0;
        #1;
        check("mid-mem reset outs", 32'(obs), 32'h0);
        check("mid-mem reset retired", 32'(retired), 32'h0);
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(K_ADDU, 1'b0, 0);
        #1;
        check("post reset retired", 32'(retired), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
